// File: rtl/pong_pkg.sv
// Shared encodings for the pong match controller: output codes, internal FSM states, screen size.
package pong_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        GS_IDLE = 2'b00,
        GS_PLAY = 2'b01,
        GS_HOLD = 2'b10,
        GS_OVER = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_PAUSE,
        ST_OVER
    } ctrl_state_e;

    // SERVE and PAUSE are indistinguishable to the ball block; both freeze the ball.
    function automatic game_state_e state_to_gs(input ctrl_state_e s);
        case (s)
            ST_IDLE:  return GS_IDLE;
            ST_PLAY:  return GS_PLAY;
            ST_SERVE: return GS_HOLD;
            ST_PAUSE: return GS_HOLD;
            ST_OVER:  return GS_OVER;
            default:  return GS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Match-controller signal bundle: buttons and scores in, game status out.
interface pong_game_ctrl_if;
    logic        btn_start;
    logic        btn_pause;
    logic [3:0]  p1_score;
    logic [3:0]  p2_score;
    logic [1:0]  game_state;
    logic [1:0]  winner;
    logic        game_rst_n;
    logic [11:0] serve_cnt;

    modport master (
        output btn_start, btn_pause, p1_score, p2_score,
        input  game_state, winner, game_rst_n, serve_cnt
    );

    modport slave (
        input  btn_start, btn_pause, p1_score, p2_score,
        output game_state, winner, game_rst_n, serve_cnt
    );
endinterface

// File: rtl/pong_btn_cond.sv
// Button conditioner: 2-flop synchroniser, level qualifier, registered rising-edge press pulse.
// BTN_DEBOUNCE_EN turns the qualifier into a DEBOUNCE_MS-sample debounce filter.
module pong_btn_cond #(
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic clk_1ms,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    logic sync1_q, sync2_q;
    logic level_q, level_d;
    logic press_q;

`ifdef BTN_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Level flips only once DEBOUNCE_MS consecutive samples disagree with it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign level_d = sync2_q;
`endif

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= level_d & ~level_q;
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match controller: serve countdown, pause, score tracking and match-over detection.
// Optional button debouncing is enabled with BTN_DEBOUNCE_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter logic [3:0]  WIN_SCORE   = 4'd7,
    parameter int unsigned SERVE_MS    = 1000,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic           clk_1ms,
    input  logic           reset,
    pong_game_ctrl_if.slave ctrl_if
);
    localparam logic [11:0] SERVE_LOAD = 12'(SERVE_MS);

    logic start_press, pause_press;

    ctrl_state_e state_q, state_d;
    game_state_e game_state_q;
    winner_e     winner_q, winner_d;
    logic [11:0] serve_cnt_q, serve_cnt_d;
    logic        game_rst_n_q, game_rst_n_d;
    logic [3:0]  p1_shadow_q, p1_shadow_d;
    logic [3:0]  p2_shadow_q, p2_shadow_d;
    logic        score_event;

    pong_btn_cond #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn_start (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .btn_i   (ctrl_if.btn_start),
        .press_o (start_press)
    );

    pong_btn_cond #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_btn_pause (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .btn_i   (ctrl_if.btn_pause),
        .press_o (pause_press)
    );

    assign score_event = (ctrl_if.p1_score != p1_shadow_q) ||
                         (ctrl_if.p2_score != p2_shadow_q);

    // Shadows follow the scores in every state so changes outside PLAY are absorbed.
    always_comb begin
        state_d      = state_q;
        serve_cnt_d  = serve_cnt_q;
        winner_d     = winner_q;
        game_rst_n_d = 1'b1;
        p1_shadow_d  = ctrl_if.p1_score;
        p2_shadow_d  = ctrl_if.p2_score;
        case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    state_d     = ST_SERVE;
                    serve_cnt_d = SERVE_LOAD;
                end
            end
            ST_SERVE: begin
                if (serve_cnt_q == 12'd1) begin
                    state_d     = ST_PLAY;
                    serve_cnt_d = '0;
                end else begin
                    serve_cnt_d = serve_cnt_q - 12'd1;
                end
            end
            ST_PLAY: begin
                if (score_event) begin
                    if (ctrl_if.p1_score >= WIN_SCORE) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_P1;
                    end else if (ctrl_if.p2_score >= WIN_SCORE) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_P2;
                    end else begin
                        state_d     = ST_SERVE;
                        serve_cnt_d = SERVE_LOAD;
                    end
                end else if (pause_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                // Rematch: the ball block is cleared, so its scores restart from zero.
                if (start_press) begin
                    game_rst_n_d = 1'b0;
                    p1_shadow_d  = '0;
                    p2_shadow_d  = '0;
                    winner_d     = WIN_NONE;
                    state_d      = ST_SERVE;
                    serve_cnt_d  = SERVE_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1ms) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            game_state_q <= GS_IDLE;
            winner_q     <= WIN_NONE;
            serve_cnt_q  <= '0;
            game_rst_n_q <= 1'b1;
            p1_shadow_q  <= '0;
            p2_shadow_q  <= '0;
        end else begin
            state_q      <= state_d;
            game_state_q <= state_to_gs(state_d);
            winner_q     <= winner_d;
            serve_cnt_q  <= serve_cnt_d;
            game_rst_n_q <= game_rst_n_d;
            p1_shadow_q  <= p1_shadow_d;
            p2_shadow_q  <= p2_shadow_d;
        end
    end

    assign ctrl_if.game_state = game_state_q;
    assign ctrl_if.winner     = winner_q;
    assign ctrl_if.serve_cnt  = serve_cnt_q;
    assign ctrl_if.game_rst_n = game_rst_n_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: rule-level match model compared every cycle,
// plus literal expectations at key points of directed button/score sequences.
module tb_pong_game_ctrl;
    localparam logic [3:0] WIN  = 4'd3;
    localparam int         SMS  = 5;
    localparam int         DBMS = 20;
`ifdef BTN_DEBOUNCE_EN
    localparam int QLEN = DBMS;
`else
    localparam int QLEN = 1;
`endif
    // Negedges from raising a button until the resulting state is visible.
    localparam int PRESS_WAIT = QLEN + 3;

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSE = 3, M_OVER = 4;

    logic clk_1ms = 1'b0;
    logic reset   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    pong_game_ctrl_if bus ();

    pong_game_ctrl #(
        .WIN_SCORE   (WIN),
        .SERVE_MS    (SMS),
        .DEBOUNCE_MS (DBMS)
    ) dut (
        .clk_1ms (clk_1ms),
        .reset   (reset),
        .ctrl_if (bus)
    );

    always #5 clk_1ms = ~clk_1ms;

    // Model state
    int       mPhase  = M_IDLE;
    int       mServe  = 0;
    int       mWinner = 0;
    int       mRstN   = 1;
    int       mSh1    = 0;
    int       mSh2    = 0;
    int       qCnt [2];
    bit       qLev [2];
    bit [2:0] pipe [2];
    bit       started = 1'b0;

    function automatic int gsOf(input int phase);
        case (phase)
            M_PLAY:          return 1;
            M_SERVE, M_PAUSE: return 2;
            M_OVER:          return 3;
            default:         return 0;
        endcase
    endfunction

    // Model: buttons qualified from raw samples, press reaches the controller three edges later.
    always @(posedge clk_1ms) begin : model
        bit raw [2];
        bit pS, pP, ev, det;
        int s1, s2;
        raw[0] = bus.btn_start;
        raw[1] = bus.btn_pause;
        s1 = int'(bus.p1_score);
        s2 = int'(bus.p2_score);
        started = 1'b1;
        if (!reset) begin
            mPhase = M_IDLE; mServe = 0; mWinner = 0; mRstN = 1; mSh1 = 0; mSh2 = 0;
            for (int b = 0; b < 2; b++) begin
                qCnt[b] = 0; qLev[b] = 1'b0; pipe[b] = 3'b000;
            end
        end else begin
            pS = pipe[0][2];
            pP = pipe[1][2];
            for (int b = 0; b < 2; b++) begin
                det = 1'b0;
                if (raw[b] != qLev[b]) begin
                    qCnt[b]++;
                    if (qCnt[b] == QLEN) begin
                        qLev[b] = raw[b];
                        qCnt[b] = 0;
                        det     = raw[b];
                    end
                end else begin
                    qCnt[b] = 0;
                end
                pipe[b] = {pipe[b][1:0], det};
            end
            ev    = (s1 != mSh1) || (s2 != mSh2);
            mSh1  = s1;
            mSh2  = s2;
            mRstN = 1;
            case (mPhase)
                M_IDLE:  if (pS) begin mPhase = M_SERVE; mServe = SMS; end
                M_SERVE: begin
                    mServe = mServe - 1;
                    if (mServe == 0) mPhase = M_PLAY;
                end
                M_PLAY: begin
                    if (ev) begin
                        if (s1 >= int'(WIN))      begin mPhase = M_OVER; mWinner = 1; end
                        else if (s2 >= int'(WIN)) begin mPhase = M_OVER; mWinner = 2; end
                        else begin mPhase = M_SERVE; mServe = SMS; end
                    end else if (pP) begin
                        mPhase = M_PAUSE;
                    end
                end
                M_PAUSE: if (pP) mPhase = M_PLAY;
                M_OVER: if (pS) begin
                    mRstN = 0; mSh1 = 0; mSh2 = 0; mWinner = 0;
                    mPhase = M_SERVE; mServe = SMS;
                end
                default: mPhase = M_IDLE;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk_1ms) begin
        if (started) begin
            checkOutput("model_game_state", 32'(bus.game_state), 32'(gsOf(mPhase)));
            checkOutput("model_winner",     32'(bus.winner),     32'(mWinner));
            checkOutput("model_game_rst_n", 32'(bus.game_rst_n), 32'(mRstN));
            checkOutput("model_serve_cnt",  32'(bus.serve_cnt),  32'(mServe));
        end
    end

    task automatic tickN(input int n);
        repeat (n) @(negedge clk_1ms);
    endtask

    // Clean press: settle, raise, wait until the effect is visible, release.
    task automatic applyStimulus(input bit isStart);
        tickN(QLEN + 2);
        if (isStart) bus.btn_start = 1'b1; else bus.btn_pause = 1'b1;
        tickN(PRESS_WAIT);
        if (isStart) bus.btn_start = 1'b0; else bus.btn_pause = 1'b0;
    endtask

    initial begin
        bus.btn_start = 1'b0;
        bus.btn_pause = 1'b0;
        bus.p1_score  = 4'd0;
        bus.p2_score  = 4'd0;
        reset = 1'b0;

        // Reset values
        tickN(3);
        reset = 1'b1;
        tickN(1);
        checkOutput("rst_game_state", 32'(bus.game_state), 32'd0);
        checkOutput("rst_winner",     32'(bus.winner),     32'd0);
        checkOutput("rst_game_rst_n", 32'(bus.game_rst_n), 32'd1);
        checkOutput("rst_serve_cnt",  32'(bus.serve_cnt),  32'd0);

        // Start press and serve countdown 5..1 then PLAY
        applyStimulus(1'b1);
        checkOutput("serve_state", 32'(bus.game_state), 32'd2);
        checkOutput("serve_cnt5",  32'(bus.serve_cnt),  32'd5);
        for (int i = 4; i >= 1; i--) begin
            tickN(1);
            checkOutput("serve_cnt_step", 32'(bus.serve_cnt), 32'(i));
        end
        tickN(1);
        checkOutput("play_state", 32'(bus.game_state), 32'd1);
        checkOutput("play_cnt0",  32'(bus.serve_cnt),  32'd0);

        // p2 scores -> serve; pause held during serve is ignored
        bus.p2_score = 4'd1;
        tickN(1);
        checkOutput("p2_point_state", 32'(bus.game_state), 32'd2);
        checkOutput("p2_point_cnt",   32'(bus.serve_cnt),  32'd5);
        bus.btn_pause = 1'b1;
        tickN(10);
        bus.btn_pause = 1'b0;
        checkOutput("pause_in_serve_ignored", 32'(bus.game_state), 32'd1);

        // Pause and resume
        applyStimulus(1'b0);
        checkOutput("paused_state", 32'(bus.game_state), 32'd2);
        checkOutput("paused_cnt",   32'(bus.serve_cnt),  32'd0);
        applyStimulus(1'b0);
        checkOutput("resumed_state", 32'(bus.game_state), 32'd1);

        // Pause press coinciding with a score event: score wins
        tickN(QLEN + 2);
        bus.btn_pause = 1'b1;
        tickN(PRESS_WAIT - 1);
        bus.p1_score = 4'd1;
        tickN(1);
        checkOutput("score_beats_pause_state", 32'(bus.game_state), 32'd2);
        checkOutput("score_beats_pause_cnt",   32'(bus.serve_cnt),  32'd5);
        bus.btn_pause = 1'b0;
        tickN(SMS);
        checkOutput("back_to_play", 32'(bus.game_state), 32'd1);

        // p1 reaches WIN_SCORE
        bus.p1_score = 4'd2;
        tickN(1 + SMS);
        bus.p1_score = 4'd3;
        tickN(1);
        checkOutput("p1_win_state",  32'(bus.game_state), 32'd3);
        checkOutput("p1_win_winner", 32'(bus.winner),     32'd1);

        // Rematch: one-cycle game_rst_n, ball block clears scores
        applyStimulus(1'b1);
        checkOutput("rematch_rst_n",  32'(bus.game_rst_n), 32'd0);
        checkOutput("rematch_winner", 32'(bus.winner),     32'd0);
        checkOutput("rematch_cnt",    32'(bus.serve_cnt),  32'd5);
        bus.p1_score = 4'd0;
        bus.p2_score = 4'd0;
        tickN(1);
        checkOutput("rematch_rst_n_release", 32'(bus.game_rst_n), 32'd1);
        tickN(SMS - 1);
        checkOutput("rematch_play", 32'(bus.game_state), 32'd1);
        tickN(3);
        checkOutput("rematch_no_retrigger", 32'(bus.game_state), 32'd1);

        // Both reach WIN_SCORE together: p1 has priority
        bus.p2_score = 4'd2;
        tickN(1 + SMS);
        bus.p1_score = 4'd3;
        bus.p2_score = 4'd3;
        tickN(1);
        checkOutput("tie_winner", 32'(bus.winner), 32'd1);

        // Second rematch, p2 wins
        applyStimulus(1'b1);
        bus.p1_score = 4'd0;
        bus.p2_score = 4'd0;
        tickN(SMS);
        bus.p2_score = 4'd3;
        tickN(1);
        checkOutput("p2_win_state",  32'(bus.game_state), 32'd3);
        checkOutput("p2_win_winner", 32'(bus.winner),     32'd2);

        // Back to IDLE: pause is ignored there
        bus.p2_score = 4'd0;
        reset = 1'b0;
        tickN(2);
        reset = 1'b1;
        applyStimulus(1'b0);
        checkOutput("idle_pause_ignored", 32'(bus.game_state), 32'd0);

        // 10-cycle start glitch
        tickN(QLEN + 2);
        bus.btn_start = 1'b1;
        tickN(10);
        bus.btn_start = 1'b0;
        tickN(30);
`ifdef BTN_DEBOUNCE_EN
        checkOutput("glitch_filtered", 32'(bus.game_state), 32'd0);
`else
        checkOutput("glitch_is_press", 32'(bus.game_state), 32'd1);
`endif

        // Reset in the middle of a countdown
        reset = 1'b0;
        tickN(1);
        reset = 1'b1;
        applyStimulus(1'b1);
        tickN(2);
        checkOutput("pre_reset_cnt3", 32'(bus.serve_cnt), 32'd3);
        reset = 1'b0;
        tickN(1);
        checkOutput("mid_serve_reset_state", 32'(bus.game_state), 32'd0);
        checkOutput("mid_serve_reset_cnt",   32'(bus.serve_cnt),  32'd0);
        reset = 1'b1;
        tickN(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
